instruction_fetch_unit: RTL and testbench

- Sits directly downstream of the program-counter register. Takes the current 32-bit PC, runs a single-outstanding read on the instruction-memory port, and holds the fetched word in an instruction register (IR) for decode.
- Drives fetch_busy, which the control unit uses to force the PC select to hold (PS=00) until the fetch completes.
- Detects misaligned PCs, bus errors and memory timeouts, and reports them as a sticky fault.

---
 rtl/instruction_fetch_unit_pkg.sv | 13 +
 rtl/instruction_fetch_unit_timeout_counter.sv | 18 +
 rtl/instruction_fetch_unit.sv | 118 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: fetch FSM state encodings and fault-cause codes.
package instruction_fetch_unit_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;
    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_BUSERR   = 2'b10;
    localparam logic [1:0] FC_TIMEOUT  = 2'b11;
endpackage

// File: rtl/instruction_fetch_unit_timeout_counter.sv
// fetch_timeout_counter: counts unacknowledged request cycles; expired on the last allowed one.
module fetch_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES);
    logic [W-1:0] cnt_q;
    assign expired = cnt_q == W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clock) begin
        if (reset || clear) cnt_q <= '0;
        else if (enable && !expired) cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: single-outstanding instruction fetch into IR with sticky
// misalign / bus-error / timeout fault reporting.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] IR_RESET       = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        advance,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic        fetch_busy,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_addr,
    output logic [31:0] fetch_count
);
    fetch_state_e state_q;
    logic        imem_req_q, ir_valid_q, fault_q, drop_q, expired;
    logic [31:0] imem_addr_q, ir_q, fault_addr_q, fetch_count_q;
    logic [1:0]  fault_cause_q;

    fetch_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (state_q != REQ),
        .enable (state_q == REQ && !imem_ack),
        .expired(expired)
    );

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign ir          = ir_q;
    assign ir_valid    = ir_valid_q;
    assign fault       = fault_q;
    assign fault_cause = fault_cause_q;
    assign fault_addr  = fault_addr_q;
    assign fetch_count = fetch_count_q;
    assign fetch_busy  = state_q == IDLE || state_q == REQ;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= '0;
            ir_q          <= IR_RESET;
            ir_valid_q    <= 1'b0;
            fault_q       <= 1'b0;
            fault_cause_q <= FC_NONE;
            fault_addr_q  <= '0;
            fetch_count_q <= '0;
            drop_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (!flush) begin
                    if (pc[1:0] != 2'b00) begin
                        state_q       <= FAULT;
                        fault_q       <= 1'b1;
                        fault_cause_q <= FC_MISALIGN;
                        fault_addr_q  <= pc;
                        ir_q          <= IR_RESET;
                    end else begin
                        state_q     <= REQ;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc;
                    end
                end
                REQ: if (imem_ack) begin
                    imem_req_q <= 1'b0;
                    drop_q     <= 1'b0;
                    // A flushed request still has to be acked; its result is discarded.
                    if (drop_q || flush) begin
                        state_q <= IDLE;
                    end else if (imem_err) begin
                        state_q       <= FAULT;
                        fault_q       <= 1'b1;
                        fault_cause_q <= FC_BUSERR;
                        fault_addr_q  <= imem_addr_q;
                        ir_q          <= IR_RESET;
                    end else begin
                        state_q       <= VALID;
                        ir_q          <= imem_rdata;
                        ir_valid_q    <= 1'b1;
                        fetch_count_q <= fetch_count_q + 32'd1;
                    end
                end else if (expired) begin
                    state_q       <= FAULT;
                    imem_req_q    <= 1'b0;
                    drop_q        <= 1'b0;
                    fault_q       <= 1'b1;
                    fault_cause_q <= FC_TIMEOUT;
                    fault_addr_q  <= imem_addr_q;
                    ir_q          <= IR_RESET;
                end else if (flush) begin
                    drop_q <= 1'b1;
                end
                VALID: if (flush || advance) begin
                    state_q    <= IDLE;
                    ir_valid_q <= 1'b0;
                end
                FAULT: if (flush) begin
                    state_q       <= IDLE;
                    fault_q       <= 1'b0;
                    fault_cause_q <= FC_NONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed and randomized fetch transactions checked
// against a transaction-level model of IR, count and fault state.
module tb_instruction_fetch_unit;
    localparam int          TO     = 16;
    localparam logic [31:0] IR_RST = 32'hDEAD0013;

    logic        clock = 1'b0, reset = 1'b1, advance = 1'b0, flush = 1'b0;
    logic [31:0] pc = '0, imem_rdata = '0;
    logic        imem_ack = 1'b0, imem_err = 1'b0;
    logic        imem_req, ir_valid, fetch_busy, fault;
    logic [31:0] imem_addr, ir, fault_addr, fetch_count;
    logic [1:0]  fault_cause;

    int total = 0, bad = 0;
    logic [31:0] m_ir = IR_RST, m_count = 0, m_faddr = 0;
    logic        m_valid = 0, m_fault = 0;
    logic [1:0]  m_cause = 0;

    instruction_fetch_unit #(.TIMEOUT_CYCLES(TO), .IR_RESET(IR_RST)) dut (
        .clock(clock), .reset(reset), .pc(pc), .advance(advance), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .imem_err(imem_err), .ir(ir), .ir_valid(ir_valid),
        .fetch_busy(fetch_busy), .fault(fault), .fault_cause(fault_cause),
        .fault_addr(fault_addr), .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ir = IR_RST; m_count = 0; m_faddr = 0; m_valid = 0; m_fault = 0; m_cause = 0;
    endtask

    task automatic chk_reset_values();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_ir", ir, IR_RST);
        chk("rst_valid", ir_valid, 0);
        chk("rst_fault", fault, 0);
        chk("rst_cause", fault_cause, 0);
        chk("rst_faddr", fault_addr, 0);
        chk("rst_count", fetch_count, 0);
        chk("rst_busy", fetch_busy, 1);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_ir"}, ir, m_ir);
        chk({tag, "_valid"}, ir_valid, m_valid);
        chk({tag, "_fault"}, fault, m_fault);
        chk({tag, "_cause"}, fault_cause, m_cause);
        chk({tag, "_faddr"}, fault_addr, m_faddr);
        chk({tag, "_count"}, fetch_count, m_count);
        chk({tag, "_busy"}, fetch_busy, !(m_valid || m_fault));
        chk({tag, "_req"}, imem_req, 0);
    endtask

    // One fetch from IDLE: waits >= TO means the ack is never given; flush_at < 0 means no flush.
    task automatic do_fetch(input logic [31:0] a, input int waits, input logic [31:0] d,
                            input bit err, input int flush_at, input bit recover_flush);
        int  n;
        bit  drop, acked;
        pc = a; flush = 0; advance = 0;
        step();
        if (a[1:0] != 2'b00) begin
            m_fault = 1; m_cause = 2'b01; m_faddr = a; m_ir = IR_RST; m_valid = 0;
        end else begin
            n = 0; drop = 0; acked = 0;
            while (1) begin
                chk("req_high", imem_req, 1);
                chk("req_addr", imem_addr, a);
                chk("req_busy", fetch_busy, 1);
                if (n == flush_at) begin flush = 1; drop = 1; end
                if (n == waits) begin imem_ack = 1; imem_rdata = d; imem_err = err; acked = 1; end
                step();
                flush = 0; imem_ack = 0; imem_err = 0; imem_rdata = $urandom;
                if (acked || n == TO - 1) break;
                n++;
            end
            if (acked && drop) begin
            end else if (!acked) begin
                m_fault = 1; m_cause = 2'b11; m_faddr = a; m_ir = IR_RST;
            end else if (err) begin
                m_fault = 1; m_cause = 2'b10; m_faddr = a; m_ir = IR_RST;
            end else begin
                m_valid = 1; m_ir = d; m_count = m_count + 1;
            end
        end
        chk_model("done");
        if (m_valid) begin
            advance = 1; flush = recover_flush;
            step();
            advance = 0; flush = 0; m_valid = 0;
            chk("leave_valid", ir_valid, 0);
            chk("ir_retained", ir, m_ir);
            chk("leave_busy", fetch_busy, 1);
        end else if (m_fault) begin
            advance = 1;
            step();
            chk("fault_sticky", fault, 1);
            flush = 1; advance = 0;
            step();
            flush = 0; m_fault = 0; m_cause = 0;
            chk("clr_fault", fault, 0);
            chk("clr_cause", fault_cause, 0);
            chk("faddr_held", fault_addr, m_faddr);
            chk("clr_busy", fetch_busy, 1);
        end
    endtask

    initial begin
        int w, fa;
        logic [31:0] a;
        step(); step();
        chk_reset_values();
        reset = 0;
        do_fetch(32'h80000000, 0, 32'h8B020020, 0, -1, 0);
        do_fetch(32'h80000004, 3, 32'hD2800541, 0, -1, 0);
        do_fetch(32'h80000006, 0, 32'h0, 0, -1, 0);
        do_fetch(32'h80000008, TO + 4, 32'h0, 0, -1, 0);
        do_fetch(32'h8000000C, TO - 1, 32'h11112222, 0, -1, 0);
        do_fetch(32'h80000010, 3, 32'h33334444, 1, 1, 0);
        do_fetch(32'h80000010, 2, 32'h55556666, 0, 2, 0);
        do_fetch(32'h80000010, 1, 32'h77778888, 1, -1, 0);
        do_fetch(32'h80000014, 0, 32'h9999AAAA, 0, -1, 1);
        for (int i = 0; i < 40; i++) begin
            a = $urandom & 32'hFFFFFFFC;
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            w = ($urandom_range(0, 7) == 0) ? TO + 2 : $urandom_range(0, 5);
            fa = ($urandom_range(0, 4) == 0 && w < TO) ? $urandom_range(0, w) : -1;
            do_fetch(a, w, $urandom, $urandom_range(0, 5) == 0, fa, $urandom_range(0, 1) == 1);
        end
        reset = 1; step(); reset = 0; model_reset();
        chk_reset_values();
        for (int i = 0; i < 4; i++) do_fetch(32'h00001000 + 4 * i, 0, $urandom, 0, -1, 0);
        chk("b2b_count", fetch_count, 4);
        pc = 32'h00002000;
        step(); step();
        chk("mid_req", imem_req, 1);
        reset = 1; step(); reset = 0; model_reset();
        chk_reset_values();
        do_fetch(32'h00003000, 1, 32'hCAFEF00D, 0, -1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
